if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch-stage controller for the LEGv8 pipeline. Owns the PC register and drives the
//  address to the combinational instruction memory. Captures the returned instruction
//  into the IF/ID pipeline register. Handles hazard stalls, branch/flush redirects,
//  halt detection and fetch faults, and feeds the decode stage.
// PARAMETERS
//  RESET_PC   64'h0          PC value loaded on reset
//  IMEM_SIZE  1024           instruction memory depth in words; fetch at/after IMEM_SIZE*4 faults
//  HALT_INST  32'hD4400000   encoding that halts fetch (HLT #0)
//  NOP_INST   32'hD503201F   encoding placed in IF/ID on bubbles
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           asynchronous, active-high reset
//  stall_i        in   1           hazard unit: hold PC and IF/ID this cycle
//  redirect_i     in   1           taken branch/flush from a later stage
//  redirect_pc_i  in   `WORD       redirect target
//  imem_pc_o      out  `WORD       address to instruction memory (= PC register)
//  imem_inst_i    in   `INST_SIZE  instruction from instruction memory, same cycle
//  ifid_valid_o   out  1           IF/ID holds a real instruction
//  ifid_pc_o      out  `WORD       PC of the IF/ID instruction
//  ifid_pc4_o     out  `WORD       that PC + 4
//  ifid_inst_o    out  `INST_SIZE  instruction in IF/ID
//  halted_o       out  1           FSM in HALT
//  fault_o        out  1           FSM in FAULT (sticky)
// BEHAVIOUR
//  - Reset (async, any time): PC=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_inst=NOP_INST,
//    state=RUN, halted_o=0, fault_o=0. Reset mid-stall or mid-halt gives the same result.
//  - imem_pc_o is the PC register, with no combinational path from inputs. An instruction
//    appears in IF/ID 1 cycle after its PC is presented.
//  - Per-edge priority: redirect_i > stall_i > normal fetch.
//  - RUN, normal: IF/ID <= {1, PC, PC+4, imem_inst_i}. PC <= PC+4, computed modulo 2^`WORD.
//  - RUN, stall_i only: PC and all IF/ID fields hold.
//  - redirect_i (RUN or HALT, stalled or not): PC <= redirect_pc_i. IF/ID gets a bubble
//    (valid=0, inst=NOP_INST, pc/pc4 hold). State goes to RUN.
//  - Redirect-target check: if redirect_pc_i[1:0]!=0 or redirect_pc_i >= IMEM_SIZE*4, the
//    state goes to FAULT instead and PC still loads the target.
//  - Sequential fetch check: in RUN, with no stall and no redirect, if PC >= IMEM_SIZE*4, the
//    state goes to FAULT, IF/ID gets a bubble and PC holds.
//  - Halt: in RUN, with no stall and no redirect, if imem_inst_i == HALT_INST:
//    - IF/ID captures the HLT as valid, so it retires downstream.
//    - PC holds and the state goes to HALT.
//  - HALT: every edge inserts a bubble and PC is frozen. Only redirect_i (the HLT was
//    speculative) or rst leaves HALT.
//  - FAULT: every edge inserts a bubble and PC is frozen. redirect_i and stall_i are ignored.
//    Only rst clears it.
//  - Outputs: halted_o = (state==HALT), fault_o = (state==FAULT), both decoded from registered state.
//  - FSM encoding: RUN=2'd0, HALT=2'd1, FAULT=2'd2. 2'd3 is unreachable and treated as FAULT.
// STRUCTURE
//  - common.vh holds `WORD, `INST_SIZE, the state encodings, and default NOP/HLT encodings
//    as `NOP_INST / `HALT_INST.
//  - One sub-module, if_id_reg: the IF/ID register with async reset, hold (stall) and
//    bubble (flush) controls, reused by later pipeline tests.
//  - if_fetch_ctrl contains the PC register, next-PC mux, range/alignment checks and FSM.
// TESTING
//  1 Reset then 3 free cycles, imem holding 0x8B020020 at words 0..2:
//    imem_pc_o goes 0 -> 4 -> 8 -> C; ifid_pc goes 0 -> 4 -> 8 with valid=1 and ifid_pc4 = ifid_pc+4.
//  2 stall_i high for 2 cycles at PC=8: PC stays 8 and IF/ID stays {1,4,8,inst1}.
//    Fetch then resumes with ifid_pc=8 next.
//  3 redirect_i with target 0x40 together with stall_i at PC=C: next cycle PC=0x40, ifid_valid=0,
//    ifid_inst=NOP_INST. One cycle later ifid_pc=0x40 and valid=1.
//  4 HLT at word 5: ifid_inst=HALT_INST with valid=1, then halted_o=1, PC frozen at 0x14, bubbles follow.
//    Then redirect_i to 0x0 gives halted_o=0 and fetch restarts at 0.
//  5 redirect_pc_i=0x42 (misaligned), and separately 0x1000 with IMEM_SIZE=1024: fault_o=1 next cycle.
//    fault_o stays 1 and valid stays 0 through later redirects, and clears only on rst.
//  6 rst asserted mid-cycle during HALT: all outputs take reset values immediately (asynchronously),
//    and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and defaults for the LEGv8 fetch stage.
package if_fetch_ctrl_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned INST_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [INST_W-1:0] inst_t;

    // Default encodings: HLT #0 and the architectural NOP.
    localparam inst_t DEF_HALT_INST = 32'hD4400000;
    localparam inst_t DEF_NOP_INST  = 32'hD503201F;

    // Fetch FSM states; 2'd3 is unreachable and behaves as FAULT.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // A fetch address is usable when word aligned and inside instruction memory.
    function automatic logic addr_ok(input word_t addr, input word_t limit);
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port, IF/ID outputs.
interface if_fetch_ctrl_if;
    import if_fetch_ctrl_pkg::*;

    logic  stall_i;
    logic  redirect_i;
    word_t redirect_pc_i;
    word_t imem_pc_o;
    inst_t imem_inst_i;
    logic  ifid_valid_o;
    word_t ifid_pc_o;
    word_t ifid_pc4_o;
    inst_t ifid_inst_o;
    logic  halted_o;
    logic  fault_o;

    // Fetch controller side: drives the memory address and the IF/ID outputs.
    modport master (
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  imem_inst_i,
        output imem_pc_o,
        output ifid_valid_o,
        output ifid_pc_o,
        output ifid_pc4_o,
        output ifid_inst_o,
        output halted_o,
        output fault_o
    );

    // Pipeline/memory side: supplies controls and instructions, consumes IF/ID.
    modport slave (
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        output imem_inst_i,
        input  imem_pc_o,
        input  ifid_valid_o,
        input  ifid_pc_o,
        input  ifid_pc4_o,
        input  ifid_inst_o,
        input  halted_o,
        input  fault_o
    );

endinterface

// File: rtl/if_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register with hold (stall) and bubble (flush) controls.
module if_id_reg
    import if_fetch_ctrl_pkg::*;
#(
    parameter inst_t NOP_INST = DEF_NOP_INST
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  word_t next_pc,
    input  word_t next_pc4,
    input  inst_t next_inst,
    output logic  valid,
    output word_t pc,
    output word_t pc4,
    output inst_t inst
);

    // Flush wins over hold; a bubble keeps pc/pc4 and swaps in a NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            pc4   <= '0;
            inst  <= NOP_INST;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (!hold) begin
            valid <= 1'b1;
            pc    <= next_pc;
            pc4   <= next_pc4;
            inst  <= next_inst;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: PC register, next-PC selection, address checks and RUN/HALT/FAULT FSM.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter word_t       RESET_PC  = 64'h0,
    parameter int unsigned IMEM_SIZE = 1024,
    parameter inst_t       HALT_INST = DEF_HALT_INST,
    parameter inst_t       NOP_INST  = DEF_NOP_INST
) (
    input logic            clk,
    input logic            rst,
    if_fetch_ctrl_if.master bus
);

    localparam word_t IMEM_LIMIT = word_t'(IMEM_SIZE) << 2;

    fetch_state_t state_q;
    fetch_state_t state_d;
    word_t        pc_q;
    word_t        pc_d;
    word_t        pc_plus4;
    logic         redirect_ok;
    logic         seq_ok;
    logic         is_halt;
    logic         ifid_hold;
    logic         ifid_flush;

    assign pc_plus4    = pc_q + word_t'(4);
    assign redirect_ok = addr_ok(bus.redirect_pc_i, IMEM_LIMIT);
    assign seq_ok      = (pc_q < IMEM_LIMIT);
    assign is_halt     = (bus.imem_inst_i == HALT_INST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Next state: redirect beats stall beats sequential fetch; FAULT is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.redirect_i) begin
                    state_d = redirect_ok ? ST_RUN : ST_FAULT;
                end else if (!bus.stall_i) begin
                    if (!seq_ok) begin
                        state_d = ST_FAULT;
                    end else if (is_halt) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (bus.redirect_i) begin
                    state_d = redirect_ok ? ST_RUN : ST_FAULT;
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // Datapath controls: next PC and IF/ID hold/bubble, per state and inputs.
    always_comb begin
        pc_d       = pc_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.redirect_i) begin
                    pc_d       = bus.redirect_pc_i;
                    ifid_flush = 1'b1;
                end else if (bus.stall_i) begin
                    ifid_hold = 1'b1;
                end else if (!seq_ok) begin
                    ifid_flush = 1'b1;
                end else if (!is_halt) begin
                    pc_d = pc_plus4;
                end
            end
            ST_HALT: begin
                ifid_flush = 1'b1;
                if (bus.redirect_i) begin
                    pc_d = bus.redirect_pc_i;
                end
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .hold      (ifid_hold),
        .flush     (ifid_flush),
        .next_pc   (pc_q),
        .next_pc4  (pc_plus4),
        .next_inst (bus.imem_inst_i),
        .valid     (bus.ifid_valid_o),
        .pc        (bus.ifid_pc_o),
        .pc4       (bus.ifid_pc4_o),
        .inst      (bus.ifid_inst_o)
    );

    assign bus.imem_pc_o = pc_q;
    assign bus.halted_o  = (state_q == ST_HALT);
    assign bus.fault_o   = (state_q != ST_RUN) && (state_q != ST_HALT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [63:0] LIMIT = 64'd4096;
    localparam logic [31:0] NOP = 32'hD503201F;
    localparam logic [31:0] HLT = 32'hD4400000;
    localparam logic [31:0] ADD = 32'h8B020020;
    localparam logic [31:0] OOR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic [31:0] imem [MEM_WORDS];

    if_fetch_ctrl_if bus();

    if_fetch_ctrl #(
        .RESET_PC  (64'h0),
        .IMEM_SIZE (MEM_WORDS),
        .HALT_INST (HLT),
        .NOP_INST  (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_inst_i = (bus.imem_pc_o < LIMIT) ? imem[bus.imem_pc_o[11:2]] : OOR;

    // Reference model state.
    logic [63:0] m_pc, m_ipc, m_ipc4;
    logic [31:0] m_inst;
    logic        m_valid, m_halt, m_fault;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_ipc = '0; m_ipc4 = '0; m_inst = NOP;
        m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_inst  = NOP;
    endtask

    // One clock edge of the fetch stage, following the behavioural rules directly.
    task automatic model_edge(input logic stall, input logic redir, input logic [63:0] tgt);
        logic [31:0] word;
        word = (m_pc < LIMIT) ? imem[m_pc[11:2]] : OOR;
        if (m_fault) begin
            model_bubble();
        end else if (redir) begin
            m_pc   = tgt;
            m_halt = 1'b0;
            model_bubble();
            if (tgt[1:0] != 2'b00 || tgt >= LIMIT) m_fault = 1'b1;
        end else if (m_halt) begin
            model_bubble();
        end else if (stall) begin
            // everything holds
        end else if (m_pc >= LIMIT) begin
            m_fault = 1'b1;
            model_bubble();
        end else begin
            m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 64'd4; m_inst = word;
            if (word == HLT) m_halt = 1'b1;
            else m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".imem_pc"}, bus.imem_pc_o, m_pc);
        check({tag, ".valid"}, 64'(bus.ifid_valid_o), 64'(m_valid));
        check({tag, ".ifid_pc"}, bus.ifid_pc_o, m_ipc);
        check({tag, ".ifid_pc4"}, bus.ifid_pc4_o, m_ipc4);
        check({tag, ".ifid_inst"}, 64'(bus.ifid_inst_o), 64'(m_inst));
        check({tag, ".halted"}, 64'(bus.halted_o), 64'(m_halt));
        check({tag, ".fault"}, 64'(bus.fault_o), 64'(m_fault));
    endtask

    task automatic step(input string tag, input logic stall, input logic redir, input logic [63:0] tgt);
        bus.stall_i = stall;
        bus.redirect_i = redir;
        bus.redirect_pc_i = tgt;
        model_edge(stall, redir, tgt);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
        #1;
        model_reset();
        compare_all("reset_async");
        @(posedge clk);
        #1;
        compare_all("reset_held");
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] tgt;
        int unsigned r;
        rst = 1'b0;
        bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
        for (int unsigned i = 0; i < MEM_WORDS; i++) imem[i] = ADD;
        imem[5] = HLT;
        model_reset();
        apply_reset();

        // Free-running fetch, then a two-cycle stall at PC=8.
        step("t1a", 1'b0, 1'b0, '0);
        step("t1b", 1'b0, 1'b0, '0);
        check("t1_pc", bus.imem_pc_o, 64'h8);
        check("t1_ifid_pc", bus.ifid_pc_o, 64'h4);
        step("t2a", 1'b1, 1'b0, '0);
        step("t2b", 1'b1, 1'b0, '0);
        check("t2_pc_hold", bus.imem_pc_o, 64'h8);
        check("t2_ifid_hold", bus.ifid_pc_o, 64'h4);
        step("t2c", 1'b0, 1'b0, '0);
        check("t2_resume", bus.ifid_pc_o, 64'h8);
        check("t2_pc_c", bus.imem_pc_o, 64'hC);

        // Redirect beats a simultaneous stall.
        step("t3a", 1'b1, 1'b1, 64'h40);
        check("t3_pc", bus.imem_pc_o, 64'h40);
        check("t3_bubble", 64'(bus.ifid_inst_o), 64'(NOP));
        step("t3b", 1'b0, 1'b0, '0);
        check("t3_ifid_pc", bus.ifid_pc_o, 64'h40);
        check("t3_valid", 64'(bus.ifid_valid_o), 64'd1);

        // Halt at word 5, then leave HALT by redirect.
        step("t4a", 1'b0, 1'b1, 64'h10);
        step("t4b", 1'b0, 1'b0, '0);
        step("t4c", 1'b0, 1'b0, '0);
        check("t4_hlt_inst", 64'(bus.ifid_inst_o), 64'(HLT));
        check("t4_hlt_valid", 64'(bus.ifid_valid_o), 64'd1);
        step("t4d", 1'b0, 1'b0, '0);
        check("t4_halted", 64'(bus.halted_o), 64'd1);
        check("t4_pc_frozen", bus.imem_pc_o, 64'h14);
        step("t4e", 1'b1, 1'b0, '0);
        step("t4f", 1'b0, 1'b1, 64'h0);
        check("t4_unhalt", 64'(bus.halted_o), 64'd0);
        step("t4g", 1'b0, 1'b0, '0);
        check("t4_restart", bus.ifid_pc_o, 64'h0);

        // Asynchronous reset in the middle of a cycle while halted.
        step("t6a", 1'b0, 1'b1, 64'h14);
        step("t6b", 1'b0, 1'b0, '0);
        step("t6c", 1'b0, 1'b0, '0);
        check("t6_halted", 64'(bus.halted_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("t6_async");
        check("t6_halted_clr", 64'(bus.halted_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("t6d", 1'b0, 1'b0, '0);
        check("t6_refetch", bus.ifid_pc_o, 64'h0);

        // Bad redirect targets and sequential run-off fault; FAULT is sticky.
        step("t5a", 1'b0, 1'b1, 64'h42);
        check("t5_misalign", 64'(bus.fault_o), 64'd1);
        step("t5b", 1'b0, 1'b1, 64'h40);
        step("t5c", 1'b1, 1'b1, 64'h0);
        check("t5_sticky", 64'(bus.fault_o), 64'd1);
        check("t5_novalid", 64'(bus.ifid_valid_o), 64'd0);
        apply_reset();
        step("t5d", 1'b0, 1'b1, 64'h1000);
        check("t5_range", 64'(bus.fault_o), 64'd1);
        apply_reset();
        step("t5e", 1'b0, 1'b1, 64'hFFC);
        step("t5f", 1'b0, 1'b0, '0);
        step("t5g", 1'b0, 1'b0, '0);
        check("t5_seq_fault", 64'(bus.fault_o), 64'd1);
        check("t5_seq_pc", bus.imem_pc_o, 64'h1000);
        apply_reset();

        // Random traffic.
        for (int unsigned i = 0; i < MEM_WORDS; i++)
            imem[i] = ($urandom_range(0, 15) == 0) ? HLT : $urandom();
        for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
            if ((m_fault || m_halt) && $urandom_range(0, 15) == 0) begin
                apply_reset();
            end else begin
                r = $urandom_range(0, 9);
                case (r)
                    0: tgt = 64'($urandom_range(0, 4095)) | 64'd1;
                    1: tgt = {$urandom(), $urandom()};
                    2: tgt = 64'hFE0 + 64'(4 * $urandom_range(0, 7));
                    default: tgt = 64'({$urandom_range(0, 1023), 2'b00});
                endcase
                step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
